// File: rtl/dtw_accel_m00_axis.sv
// dtw_accel_m00_axis: AXI4-Stream master draining DTW core results from a circular FIFO in PACKET_WORDS-beat packets
//   Clock/reset : M_AXIS_ACLK, M_AXIS_ARESETN (async assert, active-low)
//   Core side   : dtw_fifo_wren, dtw_fifo_din -> FIFO; dtw_fifo_full back-pressure; dtw_flush ends a packet early
//   Stream side : M_AXIS_TVALID/TDATA/TSTRB/TLAST out, M_AXIS_TREADY in
//   Option      : HARU_M_AXIS_PKTCNT_EN adds m_axis_pkt_count, the number of completed packets (wraps at 16 bits)
module dtw_accel_m00_axis #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PACKET_WORDS = 8
) (
  input  logic M_AXIS_ACLK,
  input  logic M_AXIS_ARESETN,
  input  logic dtw_fifo_wren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] dtw_fifo_din,
  output logic dtw_fifo_full,
  input  logic dtw_flush,
`ifdef HARU_M_AXIS_PKTCNT_EN
  output logic [15:0] m_axis_pkt_count,
`endif
  output logic M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic M_AXIS_TLAST,
  input  logic M_AXIS_TREADY
);
  localparam int W = C_M_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = PACKET_WORDS > 1 ? $clog2(PACKET_WORDS) : 1;
  typedef enum logic {IDLE, SEND} state_e;
  state_e state_q, state_d;
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [W-1:0] tdata_q, tdata_d;
  logic tlast_q, tlast_d, pend_q, pend_d;
  logic wr, ld, hs, pend_eff;
  // beat_d doubles as the packet position of a word loaded this cycle: a load
  // only happens when the register is empty or its word is handing off now.
  // pend_eff drops the flush once its TLAST beat leaves, so a word reloaded in
  // that same cycle does not become a spurious 1-beat packet.
  always_comb begin
    wr = dtw_fifo_wren && cnt_q != CW'(FIFO_DEPTH);
    hs = state_q == SEND && M_AXIS_TREADY;
    ld = cnt_q != '0 && (state_q == IDLE || M_AXIS_TREADY);
    pend_eff = pend_q && !(hs && tlast_q);
    beat_d = !hs ? beat_q : (tlast_q || beat_q == BW'(PACKET_WORDS - 1)) ? '0 : beat_q + 1'b1;
    cnt_d = cnt_q + CW'(wr) - CW'(ld);
    tdata_d = ld ? mem_q[rptr_q] : tdata_q;
    tlast_d = ld ? (beat_d == BW'(PACKET_WORDS - 1) || (pend_eff && cnt_q == CW'(1))) : tlast_q;
    pend_d = dtw_flush || pend_eff;
    state_d = ld ? SEND : hs ? IDLE : state_q;
  end
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q <= IDLE;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q <= '0;
      beat_q <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rptr_q <= rptr_q + AW'(ld);
      wptr_q <= wptr_q + AW'(wr);
      cnt_q <= cnt_d;
      beat_q <= beat_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      pend_q <= pend_d;
    end
  end
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr) mem_q[wptr_q] <= dtw_fifo_din;
  end
`ifdef HARU_M_AXIS_PKTCNT_EN
  logic [15:0] pkt_q;
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) pkt_q <= '0;
    else pkt_q <= pkt_q + 16'(hs && tlast_q);
  end
  assign m_axis_pkt_count = pkt_q;
`endif
  assign dtw_fifo_full = cnt_q == CW'(FIFO_DEPTH);
  assign M_AXIS_TVALID = state_q == SEND;
  assign M_AXIS_TDATA = tdata_q;
  assign M_AXIS_TLAST = tlast_q;
  assign M_AXIS_TSTRB = '1;
endmodule

// File: tb/tb_dtw_accel_m00_axis.sv
// tb_dtw_accel_m00_axis: random and directed stimulus against a queue-based reference model of the result streamer
module tb_dtw_accel_m00_axis;
  localparam int W = 32, D = 16, PW = 8;
  logic clk = 0, rst_n = 0, wren = 0, flush = 0, tready = 0;
  logic [W-1:0] din = '0;
  logic full, tvalid, tlast;
  logic [W-1:0] tdata;
  logic [W/8-1:0] tstrb;
  int checks = 0, failures = 0;
  logic [W-1:0] mq[$], wq[$];
  logic [W:0] log_q[$];
  bit mv, ml, mpend, hs, hsl, ld, acc, pe, stall_p;
  logic [W-1:0] md;
  logic [W:0] held;
  int lpos;
`ifdef HARU_M_AXIS_PKTCNT_EN
  logic [15:0] pkt;
  int mpc;
`endif

  dtw_accel_m00_axis #(.C_M_AXIS_TDATA_WIDTH(W), .FIFO_DEPTH(D), .PACKET_WORDS(PW)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .dtw_fifo_wren(wren), .dtw_fifo_din(din),
    .dtw_fifo_full(full), .dtw_flush(flush),
`ifdef HARU_M_AXIS_PKTCNT_EN
    .m_axis_pkt_count(pkt),
`endif
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered words plus one output slot; each
  // loaded word's packet position is counted at load time.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mv = 0; ml = 0; md = '0; lpos = 0; mpend = 0;
`ifdef HARU_M_AXIS_PKTCNT_EN
      mpc = 0;
`endif
    end else begin
      hs = mv && tready;
      hsl = hs && ml;
      acc = wren && mq.size() < D;
      ld = mq.size() > 0 && (!mv || tready);
      pe = mpend && !hsl;
`ifdef HARU_M_AXIS_PKTCNT_EN
      if (hsl) mpc = (mpc + 1) % 65536;
`endif
      if (ld) begin
        md = mq.pop_front();
        ml = (lpos == PW - 1) || (pe && mq.size() == 0);
        lpos = ml ? 0 : lpos + 1;
        mv = 1;
      end else if (hs) mv = 0;
      mpend = flush || pe;
      if (acc) begin
        mq.push_back(din);
        wq.push_back(din);
      end
    end
  end

  always @(negedge clk) begin
    chk("tvalid", tvalid, mv);
    chk("full", full, mq.size() == D);
    if (mv) begin
      chk("tdata", tdata, md);
      chk("tlast", tlast, ml);
    end
`ifdef HARU_M_AXIS_PKTCNT_EN
    chk("pkt_count", pkt, mpc);
`endif
    if (stall_p && rst_n) chk("stable", {tlast, tdata}, held);
    stall_p = rst_n && tvalid && !tready;
    held = {tlast, tdata};
    if (rst_n && tvalid && tready) log_q.push_back({tlast, tdata});
  end

  task automatic drive(input bit w, input logic [W-1:0] d, input bit f, input bit r);
    @(posedge clk);
    #1;
    wren = w; din = d; flush = f; tready = r;
  endtask

  task automatic drain();
    int n = 0;
    while ((mv || mq.size() > 0) && n < 300) begin
      drive(0, '0, 0, 1);
      n++;
    end
    checks++;
    if (n == 300) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=<300", n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0; wren = 0; flush = 0; tready = 0;
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_full", full, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    log_q.delete();
    wq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("tstrb", tstrb, 4'hF);
    // 8 words back-to-back, first-beat latency
    for (int i = 0; i < 8; i++) begin
      drive(1, W'(32'h100 + i), 0, 1);
      if (i == 1) begin @(negedge clk); chk("lat_k", tvalid, 0); end
      if (i == 2) begin @(negedge clk); chk("lat_k1", tvalid, 1); chk("lat_data", tdata, 32'h100); end
    end
    drain();
    chk("t1_len", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk("t1_beat", log_q[i], {i == 7, W'(32'h100 + i)});
    // fill while stalled: 1 word in the register + 16 buffered, 18th dropped
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(1, W'(32'h200 + i), 0, 0);
      if (i == 16) begin @(negedge clk); chk("t2_not_full", full, 0); end
      if (i == 17) begin @(negedge clk); chk("t2_full", full, 1); end
    end
    drive(0, '0, 0, 0);
    drain();
    chk("t2_len", log_q.size(), 17);
    for (int i = 0; i < 17 && i < log_q.size(); i++) chk("t2_beat", log_q[i], {i == 7 || i == 15, W'(32'h200 + i)});
    // flush closes a 3-beat packet, then a full packet follows
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, W'(32'hA0 + i), 0, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 0, 1);
    drain();
    for (int i = 0; i < 8; i++) drive(1, W'(32'hB0 + i), 0, 1);
    drain();
    chk("t3_len", log_q.size(), 11);
    if (log_q.size() == 11) begin
      chk("t3_a1", log_q[1], {1'b0, 32'hA1});
      chk("t3_a2", log_q[2], {1'b1, 32'hA2});
      chk("t3_b6", log_q[9], {1'b0, 32'hB6});
      chk("t3_b7", log_q[10], {1'b1, 32'hB7});
    end
    // 40 random words, random TREADY, no flush
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1, W'($urandom), 0, 1'($urandom % 2));
      do drive(0, '0, 0, 1'($urandom % 2)); while (mq.size() >= D || $urandom_range(0, 1) == 1);
    end
    drain();
    chk("t4_len", log_q.size(), 40);
    for (int i = 0; i < 40 && i < log_q.size() && i < wq.size(); i++) chk("t4_beat", log_q[i], {i % 8 == 7, wq[i]});
    // random writes, flushes and TREADY checked by the model each cycle
    do_reset();
    for (int i = 0; i < 200; i++) drive($urandom % 3 != 0, W'($urandom), $urandom % 8 == 0, 1'($urandom % 2));
    drain();
    chk("t5_len", log_q.size(), wq.size());
    for (int i = 0; i < log_q.size() && i < wq.size(); i++) chk("t5_data", log_q[i][W-1:0], wq[i]);
    // asynchronous reset while a beat is stalled
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, W'(32'h11 + i), 0, 0);
    drive(0, '0, 0, 0);
    @(negedge clk);
    chk("t6_pre", tvalid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_async", tvalid, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1;
    log_q.delete();
    wq.delete();
    drive(1, W'(32'h55), 0, 0);
    drive(1, W'(32'h66), 0, 0);
    drive(0, '0, 1, 0);
    drain();
    chk("t6_len", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t6_b0", log_q[0], {1'b0, 32'h55});
      chk("t6_b1", log_q[1], {1'b1, 32'h66});
    end
`ifdef HARU_M_AXIS_PKTCNT_EN
    do_reset();
    for (int i = 0; i < 24; i++) drive(1, W'(32'h300 + i), 0, 1);
    drain();
    @(negedge clk);
    chk("t7_pktcnt", pkt, 3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
